// File: rtl/tank_emulator.sv
// ---------------------------------------------------------------------------
// tank_emulator
//
// Cycle-based emulation of a water tank driven by an irrigation controller.
// A prescaler divides the clock into simulation ticks; on each tick the tank
// level moves by the net flow of the supply valve, sprinkler pump and dripper
// valve, clamped to 0..CAPACITY. Level sensors and the dry flag are registered
// decodes of the level, so they lag it by one clock.
//
// Optional feature (macro SENSOR_FAULT_EN): adds the fault_inject input, which
// forces the mid-level sensor stuck-low while held high.
//
// Ports:
//   clock                   single clock, rising edge
//   reset                   synchronous, active-high
//   watter_supply_valvule   supply valve command (adds FILL_RATE per tick)
//   splinker_bomb           sprinkler pump command (removes SPRINKLE_RATE)
//   dripper_valvule         dripper valve command (removes DRIP_RATE)
//   fault_inject            mid sensor stuck-low (SENSOR_FAULT_EN only)
//   low/mid/high_watter_level  level >= LOW_TH / MID_TH / HIGH_TH
//   level                   current volume
//   tank_state              0 IDLE, 1 FILLING, 2 DRAINING, 3 BALANCED
//   overflow                sticky: supply open while already full
//   dry                     level equals 0
// ---------------------------------------------------------------------------
module tank_emulator #(
    parameter int CAPACITY      = 200,
    parameter int INIT_LEVEL    = 0,
    parameter int FILL_RATE     = 4,
    parameter int SPRINKLE_RATE = 3,
    parameter int DRIP_RATE     = 1,
    parameter int LOW_TH        = 20,
    parameter int MID_TH        = 100,
    parameter int HIGH_TH       = 180,
    parameter int TICK_DIV      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       watter_supply_valvule,
    input  logic       splinker_bomb,
    input  logic       dripper_valvule,
`ifdef SENSOR_FAULT_EN
    input  logic       fault_inject,
`endif
    output logic       low_watter_level,
    output logic       mid_watter_level,
    output logic       high_watter_level,
    output logic [7:0] level,
    output logic [1:0] tank_state,
    output logic       overflow,
    output logic       dry
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILLING  = 2'd1,
        DRAINING = 2'd2,
        BALANCED = 2'd3
    } tank_state_t;

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    localparam logic [7:0] CAP_U  = 8'(CAPACITY);
    localparam logic [7:0] INIT_U = 8'(INIT_LEVEL);
    localparam logic [7:0] LOW_U  = 8'(LOW_TH);
    localparam logic [7:0] MID_U  = 8'(MID_TH);
    localparam logic [7:0] HIGH_U = 8'(HIGH_TH);

    // 10-bit signed working range: -255..+255 flows around an 8-bit level
    // can never wrap, so clamping only has to look at the sign and CAPACITY.
    localparam logic signed [9:0] CAP_S      = 10'(CAPACITY);
    localparam logic signed [9:0] FILL_S     = 10'(FILL_RATE);
    localparam logic signed [9:0] SPRINKLE_S = 10'(SPRINKLE_RATE);
    localparam logic signed [9:0] DRIP_S     = 10'(DRIP_RATE);

    logic [PRESC_W-1:0] prescaler;
    logic               tick;
    logic [7:0]         level_q;
    logic               any_input;
    logic signed [9:0]  net_flow;
    logic signed [9:0]  raw_sum;
    logic [7:0]         level_next;
    tank_state_t        state_q;
    tank_state_t        state_d;

    assign tick      = (prescaler == PRESC_LAST);
    assign any_input = watter_supply_valvule | splinker_bomb | dripper_valvule;

    // Prescaler: free-running 0..TICK_DIV-1, restarted by reset so a reset
    // mid-count always yields a full TICK_DIV period before the next tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Net flow for this tick with all three actuators summed together, so a
    // simultaneous fill and drain simply cancel rather than one winning.
    always_comb begin
        net_flow = '0;
        if (watter_supply_valvule) net_flow = net_flow + FILL_S;
        if (splinker_bomb)         net_flow = net_flow - SPRINKLE_S;
        if (dripper_valvule)       net_flow = net_flow - DRIP_S;

        raw_sum = $signed({2'b00, level_q}) + net_flow;

        if (raw_sum < 0) begin
            level_next = 8'd0;
        end else if (raw_sum > CAP_S) begin
            level_next = CAP_U;
        end else begin
            level_next = raw_sum[7:0];
        end
    end

    // Flow direction follows the unclamped net flow, so a full tank with the
    // supply open still reports FILLING.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            if (net_flow == 0) begin
                state_d = any_input ? BALANCED : IDLE;
            end else if (net_flow > 0) begin
                state_d = FILLING;
            end else begin
                state_d = DRAINING;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= INIT_U;
        end else if (tick) begin
            level_q <= level_next;
        end
    end

    // Overflow looks at the level before the update: trying to fill an
    // already-full tank, regardless of any drain on the same tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (tick && watter_supply_valvule && (level_q == CAP_U)) begin
            overflow <= 1'b1;
        end
    end

    // Sensors and dry are registered from the level register, giving the
    // one-clock lag a real sensor interface would show.
    always_ff @(posedge clock) begin
        if (reset) begin
            low_watter_level  <= (INIT_U >= LOW_U);
            mid_watter_level  <= (INIT_U >= MID_U);
            high_watter_level <= (INIT_U >= HIGH_U);
            dry               <= (INIT_U == 8'd0);
        end else begin
            low_watter_level  <= (level_q >= LOW_U);
`ifdef SENSOR_FAULT_EN
            mid_watter_level  <= fault_inject ? 1'b0 : (level_q >= MID_U);
`else
            mid_watter_level  <= (level_q >= MID_U);
`endif
            high_watter_level <= (level_q >= HIGH_U);
            dry               <= (level_q == 8'd0);
        end
    end

    assign level      = level_q;
    assign tank_state = state_q;

endmodule

// File: tb/tb_tank_emulator.sv
// ---------------------------------------------------------------------------
// tb_tank_emulator
//
// Self-checking bench for tank_emulator with default parameters. Each cycle
// the stimulus task drives inputs on the falling edge, steps a behavioural
// model of the tank and pushes the expected outputs to a scoreboard queue;
// after the rising edge the entry is popped and compared with the DUT.
// Directed scenarios add fixed-value checks on top of the scoreboard.
// Define SENSOR_FAULT_EN to also exercise the mid-sensor fault input.
// ---------------------------------------------------------------------------
module tb_tank_emulator;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       watter_supply_valvule = 1'b0;
    logic       splinker_bomb = 1'b0;
    logic       dripper_valvule = 1'b0;
    logic       fault_inject = 1'b0;
    logic       low_watter_level;
    logic       mid_watter_level;
    logic       high_watter_level;
    logic [7:0] level;
    logic [1:0] tank_state;
    logic       overflow;
    logic       dry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int level;
        int state;
        int ovf;
        int sens;
        int dry;
        bit chk_sens;
    } exp_t;

    exp_t sb_q[$];

    int m_presc = 0;
    int m_level = 0;
    int m_state = 0;
    int m_ovf   = 0;
    int m_sens  = 0;
    int m_dry   = 1;

    tank_emulator dut (
        .clock                 (clock),
        .reset                 (reset),
        .watter_supply_valvule (watter_supply_valvule),
        .splinker_bomb         (splinker_bomb),
        .dripper_valvule       (dripper_valvule),
`ifdef SENSOR_FAULT_EN
        .fault_inject          (fault_inject),
`endif
        .low_watter_level      (low_watter_level),
        .mid_watter_level      (mid_watter_level),
        .high_watter_level     (high_watter_level),
        .level                 (level),
        .tank_state            (tank_state),
        .overflow              (overflow),
        .dry                   (dry)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Behavioural tank: what the outputs must read after the coming edge.
    task automatic modelStep(input bit r, input bit s, input bit sp, input bit d, output exp_t e);
        int old_level;
        int net;
        int sum;
        e.chk_sens = 1'b1;
        if (r) begin
            m_presc = 0;
            m_level = 0;
            m_state = 0;
            m_ovf   = 0;
            e.chk_sens = 1'b0;
        end else begin
            old_level = m_level;
            m_sens = ((old_level >= 20) ? 4 : 0) + ((old_level >= 100) ? 2 : 0)
                   + ((old_level >= 180) ? 1 : 0);
`ifdef SENSOR_FAULT_EN
            if (fault_inject) m_sens = m_sens & 5;
`endif
            m_dry = (old_level == 0) ? 1 : 0;
            if (m_presc == 3) begin
                m_presc = 0;
                net = (s ? 4 : 0) - (sp ? 3 : 0) - (d ? 1 : 0);
                sum = old_level + net;
                m_level = (sum < 0) ? 0 : ((sum > 200) ? 200 : sum);
                if (net > 0)       m_state = 1;
                else if (net < 0)  m_state = 2;
                else               m_state = (s || sp || d) ? 3 : 0;
                if (s && old_level == 200) m_ovf = 1;
            end else begin
                m_presc++;
            end
        end
        e.level = m_level;
        e.state = m_state;
        e.ovf   = m_ovf;
        e.sens  = m_sens;
        e.dry   = m_dry;
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit sp, input bit d, input int cycles);
        exp_t e;
        exp_t got;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            reset                 = r;
            watter_supply_valvule = s;
            splinker_bomb         = sp;
            dripper_valvule       = d;
            modelStep(r, s, sp, d, e);
            sb_q.push_back(e);
            @(posedge clock);
            #1;
            got = sb_q.pop_front();
            checkOutput("sb_level", int'(level), got.level);
            checkOutput("sb_state", int'(tank_state), got.state);
            checkOutput("sb_overflow", int'(overflow), got.ovf);
            if (got.chk_sens) begin
                checkOutput("sb_sensors",
                            int'({low_watter_level, mid_watter_level, high_watter_level}), got.sens);
                checkOutput("sb_dry", int'(dry), got.dry);
            end
        end
    endtask

    function automatic int sensors();
        return int'({low_watter_level, mid_watter_level, high_watter_level});
    endfunction

    initial begin
        // Reset state
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rst_level", int'(level), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_state", int'(tank_state), 0);
        checkOutput("rst_dry", int'(dry), 1);
        checkOutput("rst_sensors", sensors(), 0);
        applyStimulus(1, 0, 0, 0, 1);

        // Scenario 1: fill from empty; sensors trip one cycle after each threshold
        applyStimulus(0, 1, 0, 0, 20);
        checkOutput("s1_level_tick5", int'(level), 20);
        checkOutput("s1_low_lag", sensors(), 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("s1_low", sensors(), 4);
        applyStimulus(0, 1, 0, 0, 80);
        checkOutput("s1_mid", sensors(), 6);
        applyStimulus(0, 1, 0, 0, 80);
        checkOutput("s1_high", sensors(), 7);
        applyStimulus(0, 1, 0, 0, 19);
        checkOutput("s1_full", int'(level), 200);
        checkOutput("s1_state", int'(tank_state), 1);
        checkOutput("s1_no_ovf", int'(overflow), 0);

        // Scenario 2: supply against a full tank
        applyStimulus(0, 1, 0, 0, 4);
        checkOutput("s2_level", int'(level), 200);
        checkOutput("s2_ovf", int'(overflow), 1);
        applyStimulus(0, 0, 0, 0, 4);
        checkOutput("s2_ovf_sticky", int'(overflow), 1);
        checkOutput("s2_idle", int'(tank_state), 0);

        // Scenario 6: reach 150, stop mid-prescaler, single-cycle reset
        applyStimulus(0, 0, 1, 0, 64);
        applyStimulus(0, 0, 0, 1, 8);
        checkOutput("s6_level150", int'(level), 150);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("s6_rst_level", int'(level), 0);
        checkOutput("s6_rst_ovf", int'(overflow), 0);
        applyStimulus(0, 1, 0, 0, 3);
        checkOutput("s6_no_early_tick", int'(level), 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("s6_first_tick", int'(level), 4);

        // Scenario 3: from 10, sprinkler and dripper together
        applyStimulus(0, 1, 0, 0, 8);
        applyStimulus(0, 0, 0, 1, 8);
        checkOutput("s3_start", int'(level), 10);
        applyStimulus(0, 0, 1, 1, 4);
        checkOutput("s3_l6", int'(level), 6);
        checkOutput("s3_draining", int'(tank_state), 2);
        applyStimulus(0, 0, 1, 1, 4);
        checkOutput("s3_l2", int'(level), 2);
        applyStimulus(0, 0, 1, 1, 4);
        checkOutput("s3_l0", int'(level), 0);
        checkOutput("s3_dry_lag", int'(dry), 0);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("s3_dry", int'(dry), 1);
        applyStimulus(0, 0, 1, 1, 3);
        checkOutput("s3_l0_hold", int'(level), 0);
        checkOutput("s3_state", int'(tank_state), 2);

        // Scenario 4: balanced flow at 100, then idle
        applyStimulus(0, 1, 0, 0, 100);
        checkOutput("s4_level", int'(level), 100);
        applyStimulus(0, 1, 1, 1, 8);
        checkOutput("s4_hold", int'(level), 100);
        checkOutput("s4_balanced", int'(tank_state), 3);
        applyStimulus(0, 0, 0, 0, 4);
        checkOutput("s4_idle", int'(tank_state), 0);

`ifdef SENSOR_FAULT_EN
        // Scenario 5: mid sensor stuck-low above the high threshold
        applyStimulus(0, 1, 0, 0, 92);
        checkOutput("s5_level", int'(level), 192);
        fault_inject = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("s5_fault", sensors(), 5);
        checkOutput("s5_level_kept", int'(level), 192);
        fault_inject = 1'b0;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("s5_restore", sensors(), 7);
`endif

        // Random traffic against the model, with rare resets
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
                          1'($urandom), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
